// File: rtl/flow_arbiter_fsm.sv
// Two-VC to two-D-FIFO flow arbiter: fixed VC0 priority, one pop per cycle,
// registered push one cycle after the pop, with configuration and error states.
module flow_arbiter_fsm #(
  parameter int          DATA_WIDTH = 6,
  parameter int          DEST_BIT   = 4,
  parameter logic [3:0]  UMBRAL_RST = 4'd2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [3:0]            umbral_VCs,
  input  logic [3:0]            umbral_Ds,
  input  logic [DATA_WIDTH-1:0] vc0_data,
  input  logic [DATA_WIDTH-1:0] vc1_data,
  input  logic                  vc0_empty,
  input  logic                  vc1_empty,
  input  logic                  d0_empty,
  input  logic                  d1_empty,
  input  logic                  d0_almost_full,
  input  logic                  d1_almost_full,
  input  logic                  fifo_error,
  output logic                  vc0_pop,
  output logic                  vc1_pop,
  output logic                  d0_push,
  output logic                  d1_push,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [3:0]            umbral_VCs_out,
  output logic [3:0]            umbral_Ds_out,
  output logic [2:0]            state_out,
  output logic                  idle_out,
  output logic                  active_out,
  output logic                  error_out
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t                state;
  logic                  vc0_elig, vc1_elig, pop_any, pop_dest, push_pend, all_empty;
  logic [DATA_WIDTH-1:0] pop_word;

  // The D-FIFO threshold leaves room for the one push still in flight,
  // so eligibility only looks at almost_full of the destination.
  always_comb begin
    vc0_elig  = !vc0_empty && !(vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full);
    vc1_elig  = !vc1_empty && !(vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full);
    vc0_pop   = !reset && (state == ST_ACTIVE) && vc0_elig;
    vc1_pop   = !reset && (state == ST_ACTIVE) && vc1_elig && !vc0_elig;
    pop_any   = vc0_pop || vc1_pop;
    pop_word  = vc0_pop ? vc0_data : vc1_data;
    pop_dest  = pop_word[DEST_BIT];
    push_pend = d0_push || d1_push;
    all_empty = vc0_empty && vc1_empty && d0_empty && d1_empty;
  end

  assign state_out = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_RESET;
      d0_push        <= 1'b0;
      d1_push        <= 1'b0;
      data_out       <= '0;
      umbral_VCs_out <= UMBRAL_RST;
      umbral_Ds_out  <= UMBRAL_RST;
      idle_out       <= 1'b0;
      active_out     <= 1'b0;
      error_out      <= 1'b0;
    end else begin
      // Push side runs independently of the next state so a pop taken on
      // the way out of ACTIVE still lands in its D FIFO.
      d0_push <= pop_any && !pop_dest;
      d1_push <= pop_any &&  pop_dest;
      if (pop_any) data_out <= pop_word;

      idle_out   <= (state == ST_IDLE);
      active_out <= (state == ST_ACTIVE);
      error_out  <= (state == ST_ERROR);

      case (state)
        ST_RESET:  if (init) state <= ST_INIT;
        ST_INIT: begin
          if (fifo_error) state <= ST_ERROR;
          else if (init) begin
            umbral_VCs_out <= umbral_VCs;
            umbral_Ds_out  <= umbral_Ds;
          end else state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (fifo_error)                   state <= ST_ERROR;
          else if (init)                    state <= ST_INIT;
          else if (!vc0_empty || !vc1_empty) state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (fifo_error)                   state <= ST_ERROR;
          else if (init)                    state <= ST_INIT;
          else if (all_empty && !push_pend) state <= ST_IDLE;
        end
        ST_ERROR:  state <= ST_ERROR;
        default:   state <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_flow_arbiter_fsm.sv
// Directed vector table plus hand sequences for flow_arbiter_fsm.
module tb_flow_arbiter_fsm;

  logic       clk = 1'b0;
  logic       reset, init, fifo_error;
  logic [3:0] umbral_VCs, umbral_Ds, umbral_VCs_out, umbral_Ds_out;
  logic [5:0] vc0_data, vc1_data, data_out;
  logic       vc0_empty, vc1_empty, d0_empty, d1_empty, d0_almost_full, d1_almost_full;
  logic       vc0_pop, vc1_pop, d0_push, d1_push, idle_out, active_out, error_out;
  logic [2:0] state_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  flow_arbiter_fsm dut (
    .clk(clk), .reset(reset), .init(init), .umbral_VCs(umbral_VCs), .umbral_Ds(umbral_Ds),
    .vc0_data(vc0_data), .vc1_data(vc1_data), .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .d0_empty(d0_empty), .d1_empty(d1_empty), .d0_almost_full(d0_almost_full),
    .d1_almost_full(d1_almost_full), .fifo_error(fifo_error), .vc0_pop(vc0_pop),
    .vc1_pop(vc1_pop), .d0_push(d0_push), .d1_push(d1_push), .data_out(data_out),
    .umbral_VCs_out(umbral_VCs_out), .umbral_Ds_out(umbral_Ds_out), .state_out(state_out),
    .idle_out(idle_out), .active_out(active_out), .error_out(error_out)
  );

  typedef struct {
    logic       rst, ini;
    logic [3:0] uv, ud;
    logic [5:0] v0d, v1d;
    logic [3:0] emp;    // {vc0_empty, vc1_empty, d0_empty, d1_empty}
    logic [1:0] af;     // {d0_almost_full, d1_almost_full}
    logic       err;
    logic [1:0] e_pop;  // {vc1_pop, vc0_pop} before the edge
    logic [2:0] e_st;
    logic [1:0] e_push; // {d1_push, d0_push}
    logic [5:0] e_data;
    logic [2:0] e_flg;  // {error_out, active_out, idle_out}
    logic [3:0] e_uv, e_ud;
  } vec_t;

  localparam logic [5:0] A = 6'b000101, B = 6'b010110, C = 6'b000100;

  function automatic vec_t v(logic rst, logic ini, logic [3:0] uv, logic [3:0] ud,
      logic [5:0] v0d, logic [5:0] v1d, logic [3:0] emp, logic [1:0] af, logic err,
      logic [1:0] e_pop, logic [2:0] e_st, logic [1:0] e_push, logic [5:0] e_data,
      logic [2:0] e_flg, logic [3:0] e_uv, logic [3:0] e_ud);
    vec_t r;
    r.rst = rst; r.ini = ini; r.uv = uv; r.ud = ud; r.v0d = v0d; r.v1d = v1d;
    r.emp = emp; r.af = af; r.err = err; r.e_pop = e_pop; r.e_st = e_st;
    r.e_push = e_push; r.e_data = e_data; r.e_flg = e_flg; r.e_uv = e_uv; r.e_ud = e_ud;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    reset = t.rst; init = t.ini; umbral_VCs = t.uv; umbral_Ds = t.ud;
    vc0_data = t.v0d; vc1_data = t.v1d;
    {vc0_empty, vc1_empty, d0_empty, d1_empty} = t.emp;
    {d0_almost_full, d1_almost_full} = t.af;
    fifo_error = t.err;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    // reset and configuration
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(1,0,2,2,0,0,4'b1111,2'b00,0, 2'b00,3'd0,2'b00,6'd0,3'b000,2,2));
    tbl.push_back(v(0,1,5,3,0,0,4'b1111,2'b00,0, 2'b00,3'd1,2'b00,6'd0,3'b000,2,2));
    tbl.push_back(v(0,1,5,3,0,0,4'b1111,2'b00,0, 2'b00,3'd1,2'b00,6'd0,3'b000,5,3));
    tbl.push_back(v(0,1,2,2,0,0,4'b1111,2'b00,0, 2'b00,3'd1,2'b00,6'd0,3'b000,2,2));
    tbl.push_back(v(0,0,2,2,0,0,4'b1111,2'b00,0, 2'b00,3'd2,2'b00,6'd0,3'b000,2,2));
    tbl.push_back(v(0,0,2,2,0,0,4'b1111,2'b00,0, 2'b00,3'd2,2'b00,6'd0,3'b001,2,2));
    // single word VC0 -> D0, then drain back to IDLE
    tbl.push_back(v(0,0,2,2,A,0,4'b0111,2'b00,0, 2'b00,3'd3,2'b00,6'd0,3'b001,2,2));
    tbl.push_back(v(0,0,2,2,A,0,4'b0111,2'b00,0, 2'b01,3'd3,2'b01,A,   3'b010,2,2));
    tbl.push_back(v(0,0,2,2,A,0,4'b1101,2'b00,0, 2'b00,3'd3,2'b00,A,   3'b010,2,2));
    tbl.push_back(v(0,0,2,2,A,0,4'b1111,2'b00,0, 2'b00,3'd2,2'b00,A,   3'b010,2,2));
    tbl.push_back(v(0,0,2,2,A,0,4'b1111,2'b00,0, 2'b00,3'd2,2'b00,A,   3'b001,2,2));
    // both VCs: VC0 priority, then VC1 once D1 almost full
    tbl.push_back(v(0,0,2,2,B,C,4'b0011,2'b00,0, 2'b00,3'd3,2'b00,A,   3'b001,2,2));
    tbl.push_back(v(0,0,2,2,B,C,4'b0011,2'b00,0, 2'b01,3'd3,2'b10,B,   3'b010,2,2));
    tbl.push_back(v(0,0,2,2,B,C,4'b0010,2'b01,0, 2'b10,3'd3,2'b01,C,   3'b010,2,2));
    // both D FIFOs almost full: stall, then release D0
    tbl.push_back(v(0,0,2,2,B,C,4'b0010,2'b11,0, 2'b00,3'd3,2'b00,C,   3'b010,2,2));
    tbl.push_back(v(0,0,2,2,B,C,4'b0010,2'b11,0, 2'b00,3'd3,2'b00,C,   3'b010,2,2));
    tbl.push_back(v(0,0,2,2,B,C,4'b0010,2'b01,0, 2'b10,3'd3,2'b01,C,   3'b010,2,2));
    // error: in-flight push completes, ERROR sticks through init
    tbl.push_back(v(0,0,2,2,B,C,4'b0010,2'b01,1, 2'b10,3'd4,2'b01,C,   3'b010,2,2));
    tbl.push_back(v(0,1,2,2,B,C,4'b0010,2'b01,0, 2'b00,3'd4,2'b00,C,   3'b100,2,2));
    tbl.push_back(v(0,1,2,2,B,C,4'b0010,2'b01,0, 2'b00,3'd4,2'b00,C,   3'b100,2,2));
    tbl.push_back(v(1,0,2,2,B,C,4'b0010,2'b01,0, 2'b00,3'd0,2'b00,6'd0,3'b000,2,2));
    // init from ACTIVE with a pop in flight, then reset drops a pop/push
    tbl.push_back(v(0,1,2,2,0,0,4'b1111,2'b00,0, 2'b00,3'd1,2'b00,6'd0,3'b000,2,2));
    tbl.push_back(v(0,0,2,2,0,0,4'b1111,2'b00,0, 2'b00,3'd2,2'b00,6'd0,3'b000,2,2));
    tbl.push_back(v(0,0,2,2,A,0,4'b0111,2'b00,0, 2'b00,3'd3,2'b00,6'd0,3'b001,2,2));
    tbl.push_back(v(0,1,2,2,A,0,4'b0111,2'b00,0, 2'b01,3'd1,2'b01,A,   3'b010,2,2));
    tbl.push_back(v(0,1,7,9,A,0,4'b0111,2'b00,0, 2'b00,3'd1,2'b00,A,   3'b000,7,9));
    tbl.push_back(v(0,0,7,9,A,0,4'b0111,2'b00,0, 2'b00,3'd2,2'b00,A,   3'b000,7,9));
    tbl.push_back(v(0,0,7,9,A,0,4'b0111,2'b00,0, 2'b00,3'd3,2'b00,A,   3'b001,7,9));
    tbl.push_back(v(1,0,7,9,A,0,4'b0111,2'b00,0, 2'b00,3'd0,2'b00,6'd0,3'b000,2,2));
    // fifo_error from INIT; ignored in RESET
    tbl.push_back(v(0,1,2,2,0,0,4'b1111,2'b00,0, 2'b00,3'd1,2'b00,6'd0,3'b000,2,2));
    tbl.push_back(v(0,1,2,2,0,0,4'b1111,2'b00,1, 2'b00,3'd4,2'b00,6'd0,3'b000,2,2));
    tbl.push_back(v(1,0,2,2,0,0,4'b1111,2'b00,0, 2'b00,3'd0,2'b00,6'd0,3'b000,2,2));
    tbl.push_back(v(0,0,2,2,0,0,4'b1111,2'b00,1, 2'b00,3'd0,2'b00,6'd0,3'b000,2,2));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      chk("pop", i, {6'd0, vc1_pop, vc0_pop}, {6'd0, tbl[i].e_pop});
      tick();
      chk("state", i, {5'd0, state_out}, {5'd0, tbl[i].e_st});
      chk("push",  i, {6'd0, d1_push, d0_push}, {6'd0, tbl[i].e_push});
      chk("data",  i, {2'd0, data_out}, {2'd0, tbl[i].e_data});
      chk("flags", i, {5'd0, error_out, active_out, idle_out}, {5'd0, tbl[i].e_flg});
      chk("umbral", i, {umbral_VCs_out, umbral_Ds_out}, {tbl[i].e_uv, tbl[i].e_ud});
    end

    // Hand sequence: a pending push alone keeps ACTIVE alive for one more cycle.
    drive(v(0,1,2,2,0,0,4'b1111,2'b00,0, 0,0,0,0,0,0,0)); tick();
    init = 1'b0; tick();
    chk("seq_idle", 100, {5'd0, state_out}, 8'd2);
    vc0_empty = 1'b0; vc0_data = A; tick();
    #1 chk("seq_pop", 101, {6'd0, vc1_pop, vc0_pop}, 8'b01);
    tick();
    vc0_empty = 1'b1;
    #1 chk("seq_nopop", 102, {6'd0, vc1_pop, vc0_pop}, 8'b00);
    tick();
    chk("seq_hold_active", 103, {5'd0, state_out}, 8'd3);
    tick();
    chk("seq_to_idle", 104, {5'd0, state_out}, 8'd2);
    chk("seq_flags", 105, {5'd0, error_out, active_out, idle_out}, 8'b010);

    // Hand sequence: VC1 alone to D1, while IDLE produces no pop.
    vc1_empty = 1'b0; vc1_data = B;
    #1 chk("seq_idle_nopop", 106, {6'd0, vc1_pop, vc0_pop}, 8'b00);
    tick();
    #1 chk("seq_vc1_pop", 107, {6'd0, vc1_pop, vc0_pop}, 8'b10);
    tick();
    vc1_empty = 1'b1;
    chk("seq_d1_push", 108, {6'd0, d1_push, d0_push}, 8'b10);
    chk("seq_d1_data", 109, {2'd0, data_out}, {2'd0, B});
    tick();
    chk("seq_push_clear", 110, {6'd0, d1_push, d0_push}, 8'b00);
    chk("seq_data_hold", 111, {2'd0, data_out}, {2'd0, B});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
